// File: rtl/vec_mac_sequencer.sv
// Control sequencer for the 8x8 pipelined vector multiplier: issues VEC_LEN element
// indices with MAC enables, waits out the pipeline latency, then hands the result off.
module vec_mac_sequencer #(
   parameter int VEC_LEN  = 8,
   parameter int IDX_W    = 4,
   parameter int PIPE_LAT = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic             abort,
   output logic             idx_en,
   output logic [IDX_W-1:0] idx,
   output logic             mac_clear,
   output logic             mac_en,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int              CNT_W      = 4;
   localparam logic [IDX_W-1:0] IDX_IDLE  = '1;
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(VEC_LEN - 1);
   // Clamped so the compare stays legal when PIPE_LAT=0 (DRAIN is then unreachable).
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] drain_cnt;
   logic [CNT_W-1:0] drain_cnt_nxt;
   logic [IDX_W-1:0] idx_nxt;
   logic             idx_en_nxt;
   logic             mac_clear_nxt;
   logic             mac_en_nxt;
   logic             res_valid_nxt;
   logic             busy_nxt;

   assign start_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         drain_cnt <= '0;
         idx       <= IDX_IDLE;
         idx_en    <= 1'b0;
         mac_clear <= 1'b0;
         mac_en    <= 1'b0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
         idx       <= idx_nxt;
         idx_en    <= idx_en_nxt;
         mac_clear <= mac_clear_nxt;
         mac_en    <= mac_en_nxt;
         res_valid <= res_valid_nxt;
         busy      <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start_valid) state_nxt = RUN;
         RUN:     if (idx == IDX_LAST) state_nxt = (PIPE_LAT > 0) ? DRAIN : DONE;
         DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
         DONE:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   // Outputs are precomputed from the upcoming state so they appear registered.
   always_comb begin
      idx_nxt       = IDX_IDLE;
      idx_en_nxt    = 1'b0;
      mac_clear_nxt = 1'b0;
      mac_en_nxt    = 1'b0;
      drain_cnt_nxt = '0;
      if (state_nxt == RUN) begin
         idx_en_nxt = 1'b1;
         mac_en_nxt = 1'b1;
         if (state == RUN) begin
            idx_nxt = idx + IDX_W'(1);
         end else begin
            idx_nxt       = '0;
            mac_clear_nxt = 1'b1;
         end
      end
      if ((state == DRAIN) && (state_nxt == DRAIN)) drain_cnt_nxt = drain_cnt + CNT_W'(1);
      res_valid_nxt = (state_nxt == DONE);
      busy_nxt      = (state_nxt != IDLE);
   end

endmodule
